iq_data_tx: RTL and testbench
=============================

Name: iq_data_tx

Overview:
- CPRI-style basic-frame transmitter. Other end of the link from iq_data_rx.
- Generates the slot sequence counter (0..95) and the basic-frame counter (0..255).
- Inserts control words, sync header and idle gaps into the 64-bit stream, and pulls payload IQ words from an upstream valid/ready stream into payload slots.
- Drives the same data/seq/mask/ctrl bundle that iq_data_rx consumes.

Parameters:
- DW, 64, tx data/mask width.
- SEQ_MAX, 95, last slot index in a basic frame.
- X_MAX, 255, last basic-frame index in a hyperframe.
- SYNC_WORD, 64'h11114321_11114321, header word sent in slots 4 and 5.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_hfp  in  1  hyperframe restart pulse (synchronous to i_clk).
- i_iq_data  in  64  payload word.
- i_iq_vld  in  1  payload word valid.
- o_iq_rdy  out  1  block accepts i_iq_data this cycle.
- o_cpri_tx_data  out  64  tx data.
- o_cpri_tx_seq  out  7  slot index of current o_cpri_tx_data.
- o_cpri_tx_mask  out  64  byte-lane/bit mask.
- o_cpri_tx_crtl  out  8  control-character flags.
- o_hfp  out  1  high on the cycle where seq==0 and x==0 are output.
- o_underflow  out  1  sticky; set when a payload slot had no valid word.

Behaviour:
- Reset: all outputs 0, internal seq/x counters 0, o_underflow 0.
- Counters:
  - seq increments every cycle and wraps SEQ_MAX->0.
  - x increments when seq==SEQ_MAX and wraps X_MAX->0.
  - i_hfp forces next seq=0 and x=0. i_hfp wins over wrap and increment.
- Slot map, evaluated on the slot being output:
  - seq 0..1: control. crtl=8'hFF; data/mask from CM table.
    - x=81 -> data 64'h5100_0000_0000_0000.
    - x=144 -> 64'h9000_..., x=145 -> 64'h9100_....
    - x=208 -> 64'hD000_..., x=209 -> 64'hD100_....
    - For those x: mask all ones. Any other x: data 0, mask 0.
  - seq 2..3: idle. data 0, mask all ones, crtl 0.
  - seq 4..5: SYNC_WORD, mask all ones, crtl 0.
  - seq 6..26 and 48..95: payload (69 words per basic frame). mask all ones, crtl 0.
  - seq 27..47: gap. data 0, mask all ones, crtl 0.
- Pipeline: all outputs registered, one cycle latency.
  - o_iq_rdy is combinational = (next seq is a payload slot) and not in reset.
  - A transfer occurs when i_iq_vld && o_iq_rdy. The word appears on o_cpri_tx_data on the next cycle, alongside its seq.
- Underflow: o_iq_rdy high with i_iq_vld low -> output data 0 in that slot and set o_underflow. Cleared only by reset.
- i_hfp mid-frame:
  - The current partial frame is truncated; next output is seq=0, x=0.
  - o_iq_rdy follows the new next-seq. It is low in the i_hfp cycle because next seq=0 is control.
- o_hfp is registered with the outputs and asserted exactly when the output seq=0 and x=0.
- Async reset mid-operation: outputs drop to 0 immediately. Counting restarts at seq 0, x 0 on the first clock after release.

Optional Feature:
- Macro IQ_TX_TEST_PATTERN_EN.
- When defined:
  - Adds input port i_test_mode (1 bit).
  - With i_test_mode=1, payload slots carry {4{cnt16}}, where cnt16 is a 16-bit counter. It increments per payload slot, wraps at 16'hFFFF, and resets to 0 on i_hfp.
  - o_iq_rdy is held 0 and o_underflow is not set.
- When undefined: no port, no counter; behaviour as above.

Decomposition:
- Package iq_tx_pkg:
  - Slot boundary constants: CTRL_END=1, SYNC_FIRST=4, SYNC_LAST=5, PL0_FIRST=6, PL0_LAST=26, GAP_LAST=47, PL1_FIRST=48.
  - Slot-type enum: CTRL, IDLE, SYNC, PAYLOAD, GAP.
  - CM table x indices and words.
- Sub-module iq_tx_cm_gen: combinational x -> {cm_data, cm_mask}.

Test Plan:
1. Reset release, then i_hfp pulse, i_iq_vld=1 with incrementing data → seq 0..95 repeats; crtl=FF only at seq 0,1; SYNC_WORD at seq 4,5; 69 words consumed per frame, in order, with none lost.
2. Run to x=81, 144, 145, 208, 209 → seq 0,1 data 64'h5100..., 9000..., 9100..., D000..., D100..., mask all ones; x=82 gives data 0, mask 0.
3. Deassert i_iq_vld for slot 10 → output at seq 10 is 0; o_underflow rises and stays high; slot 11 carries the next word.
4. i_hfp asserted at seq 50, x=7 → next output seq=0, x=0, o_hfp=1; o_iq_rdy low that cycle.
5. Async reset asserted at seq 30 → outputs 0 immediately; after release seq restarts at 0.
6. IQ_TX_TEST_PATTERN_EN defined, i_test_mode=1 → payload words {4{16'h0000}}, {4{16'h0001}}, ...; o_iq_rdy=0; o_underflow=0.

Source files
------------

// File: rtl/iq_tx_pkg.sv
// Shared definitions for the CPRI-style basic-frame transmitter.
// Purpose: slot boundaries, slot classes and control-word table contents.
// Latency: none (definitions only). Backpressure: not applicable.
package iq_tx_pkg;

  localparam int DW_DEF = 64;
  localparam int SEQ_MAX_DEF = 95;
  localparam int X_MAX_DEF = 255;
  localparam logic [63:0] SYNC_WORD_DEF = 64'h11114321_11114321;

  // Slot boundaries inside one basic frame
  localparam logic [6:0] CTRL_END   = 7'd1;
  localparam logic [6:0] SYNC_FIRST = 7'd4;
  localparam logic [6:0] SYNC_LAST  = 7'd5;
  localparam logic [6:0] PL0_FIRST  = 7'd6;
  localparam logic [6:0] PL0_LAST   = 7'd26;
  localparam logic [6:0] GAP_LAST   = 7'd47;
  localparam logic [6:0] PL1_FIRST  = 7'd48;

  typedef enum logic [2:0] {CTRL, IDLE, SYNC, PAYLOAD, GAP} slot_t;

  // Basic frames whose control slots carry a non-zero control word
  localparam logic [7:0] CM_X_81  = 8'd81;
  localparam logic [7:0] CM_X_144 = 8'd144;
  localparam logic [7:0] CM_X_145 = 8'd145;
  localparam logic [7:0] CM_X_208 = 8'd208;
  localparam logic [7:0] CM_X_209 = 8'd209;

  localparam logic [63:0] CM_W_81  = 64'h5100_0000_0000_0000;
  localparam logic [63:0] CM_W_144 = 64'h9000_0000_0000_0000;
  localparam logic [63:0] CM_W_145 = 64'h9100_0000_0000_0000;
  localparam logic [63:0] CM_W_208 = 64'hD000_0000_0000_0000;
  localparam logic [63:0] CM_W_209 = 64'hD100_0000_0000_0000;

  // Classify a slot index; indices above the last payload slot never occur
  function automatic slot_t slot_type(input logic [6:0] seq);
    slot_t t;
    if (seq <= CTRL_END)        t = CTRL;
    else if (seq < SYNC_FIRST)  t = IDLE;
    else if (seq <= SYNC_LAST)  t = SYNC;
    else if (seq <= PL0_LAST)   t = PAYLOAD;
    else if (seq < PL1_FIRST)   t = GAP;
    else                        t = PAYLOAD;
    return t;
  endfunction

endpackage

// File: rtl/iq_data_tx_if.sv
// Bundle between the transmitter, its payload source and the link side.
// Latency: none (wires only). Backpressure: o_iq_rdy qualifies i_iq_vld.
// master = transmitter side, slave = payload source / link consumer side.
interface iq_data_tx_if #(parameter int DW = 64);
  logic [DW-1:0] i_iq_data;
  logic          i_iq_vld;
  logic          o_iq_rdy;
  logic [DW-1:0] o_cpri_tx_data;
  logic [6:0]    o_cpri_tx_seq;
  logic [DW-1:0] o_cpri_tx_mask;
  logic [7:0]    o_cpri_tx_crtl;

  modport master (
    input  i_iq_data, i_iq_vld,
    output o_iq_rdy, o_cpri_tx_data, o_cpri_tx_seq, o_cpri_tx_mask, o_cpri_tx_crtl
  );

  modport slave (
    output i_iq_data, i_iq_vld,
    input  o_iq_rdy, o_cpri_tx_data, o_cpri_tx_seq, o_cpri_tx_mask, o_cpri_tx_crtl
  );
endinterface

// File: rtl/iq_tx_cm_gen.sv
// Control-word lookup: basic-frame index -> control data and mask.
// Latency: combinational. Backpressure: none.
// Only a handful of frames carry a word; every other frame sends data 0, mask 0.
module iq_tx_cm_gen
  import iq_tx_pkg::*;
(
  input  logic [7:0]  x_i,
  output logic [63:0] cm_data_o,
  output logic [63:0] cm_mask_o
);

  // Table lookup; mask opens all lanes only when a word is defined
  always_comb begin
    cm_data_o = '0;
    cm_mask_o = '0;
    case (x_i)
      CM_X_81:  begin cm_data_o = CM_W_81;  cm_mask_o = '1; end
      CM_X_144: begin cm_data_o = CM_W_144; cm_mask_o = '1; end
      CM_X_145: begin cm_data_o = CM_W_145; cm_mask_o = '1; end
      CM_X_208: begin cm_data_o = CM_W_208; cm_mask_o = '1; end
      CM_X_209: begin cm_data_o = CM_W_209; cm_mask_o = '1; end
      default:  begin cm_data_o = '0;       cm_mask_o = '0; end
    endcase
  end

endmodule

// File: rtl/iq_data_tx.sv
// Basic-frame transmitter: slot/frame counters, control/sync/gap insertion, payload pull.
// Latency: one cycle from accepted payload word to o_cpri_tx_data. Backpressure: o_iq_rdy
// only in payload slots; a missing word sends 0 and sets sticky o_underflow.
// Optional IQ_TX_TEST_PATTERN_EN adds i_test_mode, replacing payload with a 16-bit counter.
module iq_data_tx
  import iq_tx_pkg::*;
#(
  parameter int          DW        = DW_DEF,
  parameter int          SEQ_MAX   = SEQ_MAX_DEF,
  parameter int          X_MAX     = X_MAX_DEF,
  parameter logic [63:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hfp,
`ifdef IQ_TX_TEST_PATTERN_EN
  input  logic             i_test_mode,
`endif
  iq_data_tx_if.master     tx,
  output logic             o_hfp,
  output logic             o_underflow
);

  // seq_q/x_q name the slot that goes out on the next clock unless i_hfp overrides it
  logic [6:0]    seq_q, seq_d, eff_seq;
  logic [7:0]    x_q, x_d, eff_x;
  slot_t         slot;
  logic          rdy, take, test_on;
  logic [DW-1:0] pat;
  logic [63:0]   cm_data, cm_mask;

  logic [DW-1:0] data_q, data_d, mask_q, mask_d;
  logic [6:0]    oseq_q;
  logic [7:0]    crtl_q, crtl_d;
  logic          hfp_q, hfp_d, uf_q, uf_d;

  iq_tx_cm_gen u_cm_gen (
    .x_i       (eff_x),
    .cm_data_o (cm_data),
    .cm_mask_o (cm_mask)
  );

  // Slot about to be emitted and the counter advance after it; restart pulse wins
  always_comb begin
    eff_seq = i_hfp ? 7'd0 : seq_q;
    eff_x   = i_hfp ? 8'd0 : x_q;
    seq_d   = eff_seq + 7'd1;
    x_d     = eff_x;
    if (eff_seq == 7'(SEQ_MAX)) begin
      seq_d = 7'd0;
      x_d   = (eff_x == 8'(X_MAX)) ? 8'd0 : eff_x + 8'd1;
    end
  end

  assign slot = slot_type(eff_seq);
  assign rdy  = (slot == PAYLOAD) && i_rst_n && !test_on;
  assign take = rdy && tx.i_iq_vld;

`ifdef IQ_TX_TEST_PATTERN_EN
  logic [15:0] cnt_q, cnt_d;

  assign test_on = i_test_mode;
  assign pat     = {4{cnt_q}};

  // Pattern counter steps once per payload slot in test mode; restart pulse clears it
  always_comb begin
    cnt_d = cnt_q;
    if (i_hfp)                            cnt_d = 16'd0;
    else if (test_on && slot == PAYLOAD)  cnt_d = cnt_q + 16'd1;
  end

  // Pattern counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= 16'd0;
    else          cnt_q <= cnt_d;
  end
`else
  assign test_on = 1'b0;
  assign pat     = '0;
`endif

  // Output word selection for the slot being emitted
  always_comb begin
    data_d = '0;
    mask_d = '1;
    crtl_d = 8'h00;
    uf_d   = uf_q;
    hfp_d  = (eff_seq == 7'd0) && (eff_x == 8'd0);
    case (slot)
      CTRL: begin
        data_d = cm_data;
        mask_d = cm_mask;
        crtl_d = 8'hFF;
      end
      SYNC:    data_d = SYNC_WORD;
      PAYLOAD: begin
        if (test_on)   data_d = pat;
        else if (take) data_d = tx.i_iq_data;
        else begin
          data_d = '0;
          uf_d   = 1'b1;
        end
      end
      default: data_d = '0;
    endcase
  end

  // Counters and registered output bundle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seq_q  <= 7'd0;
      x_q    <= 8'd0;
      data_q <= '0;
      mask_q <= '0;
      oseq_q <= 7'd0;
      crtl_q <= 8'h00;
      hfp_q  <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      x_q    <= x_d;
      data_q <= data_d;
      mask_q <= mask_d;
      oseq_q <= eff_seq;
      crtl_q <= crtl_d;
      hfp_q  <= hfp_d;
      uf_q   <= uf_d;
    end
  end

  assign tx.o_iq_rdy       = rdy;
  assign tx.o_cpri_tx_data = data_q;
  assign tx.o_cpri_tx_seq  = oseq_q;
  assign tx.o_cpri_tx_mask = mask_q;
  assign tx.o_cpri_tx_crtl = crtl_q;
  assign o_hfp             = hfp_q;
  assign o_underflow       = uf_q;

endmodule

// File: tb/tb_iq_data_tx.sv
// Self-checking bench for iq_data_tx: reference model works on a linear slot index
// (frame*96 + slot) and a stream of driven words; plus a vector table and corner sequences.
module tb_iq_data_tx;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SYNC = 64'h11114321_11114321;
  localparam int FRAME = 96;
  localparam int HYPER = 96 * 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, hfp, test_mode, o_hfp_w, o_uf_w;

  iq_data_tx_if bus ();

  iq_data_tx dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hfp       (hfp),
`ifdef IQ_TX_TEST_PATTERN_EN
    .i_test_mode (test_mode),
`endif
    .tx          (bus.master),
    .o_hfp       (o_hfp_w),
    .o_underflow (o_uf_w)
  );

  int total = 0;
  int bad = 0;

  // reference model state
  int          m_slot;
  bit          m_uf;
  logic [15:0] m_cnt;
  int          lseq, lx;
  bit          ltake;
  logic [63:0] w;

  typedef struct {
    int          x;
    int          seq;
    logic [63:0] data;
    logic [63:0] mask;
    logic [7:0]  crtl;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_pl(input int s);
    return (s >= 6 && s <= 26) || (s >= 48 && s <= 95);
  endfunction

  function automatic logic [63:0] cm_word(input int x);
    logic [63:0] r;
    case (x)
      81:      r = 64'h5100_0000_0000_0000;
      144:     r = 64'h9000_0000_0000_0000;
      145:     r = 64'h9100_0000_0000_0000;
      208:     r = 64'hD000_0000_0000_0000;
      209:     r = 64'hD100_0000_0000_0000;
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock: drive inputs, check ready, predict and check the registered outputs
  task automatic step(input bit vld, input logic [63:0] dat, input bit h, input bit tm);
    int s, x;
    bit rdy_e, take, eh;
    logic [63:0] ed, em;
    logic [7:0] ec;
    @(negedge clk);
    bus.i_iq_vld  = vld;
    bus.i_iq_data = dat;
    hfp           = h;
    test_mode     = tm;
    if (h) begin
      m_slot = 0;
      m_cnt  = 16'd0;
    end
    s = m_slot % FRAME;
    x = m_slot / FRAME;
    rdy_e = is_pl(s) && !tm;
    #1;
    chk("iq_rdy", {63'd0, bus.o_iq_rdy}, {63'd0, rdy_e});
    take = rdy_e && vld;
    ed = 64'h0; em = ONES; ec = 8'h00;
    if (s < 2) begin
      ed = cm_word(x);
      em = (ed != 64'h0) ? ONES : 64'h0;
      ec = 8'hFF;
    end else if (s == 4 || s == 5) begin
      ed = SYNC;
    end else if (is_pl(s)) begin
      if (tm) begin
        ed = {4{m_cnt}};
        m_cnt = m_cnt + 16'd1;
      end else if (take) begin
        ed = dat;
      end else begin
        m_uf = 1'b1;
      end
    end
    eh = (m_slot == 0);
    @(posedge clk);
    #1;
    chk("seq",       {57'd0, bus.o_cpri_tx_seq}, 64'(s));
    chk("data",      bus.o_cpri_tx_data, ed);
    chk("mask",      bus.o_cpri_tx_mask, em);
    chk("crtl",      {56'd0, bus.o_cpri_tx_crtl}, {56'd0, ec});
    chk("o_hfp",     {63'd0, o_hfp_w}, {63'd0, eh});
    chk("underflow", {63'd0, o_uf_w}, {63'd0, m_uf});
    lseq   = s;
    lx     = x;
    ltake  = take;
    m_slot = (m_slot + 1) % HYPER;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"}, bus.o_cpri_tx_data, 64'h0);
    chk({tag, "_seq"},  {57'd0, bus.o_cpri_tx_seq}, 64'h0);
    chk({tag, "_mask"}, bus.o_cpri_tx_mask, 64'h0);
    chk({tag, "_crtl"}, {56'd0, bus.o_cpri_tx_crtl}, 64'h0);
    chk({tag, "_hfp"},  {63'd0, o_hfp_w}, 64'h0);
    chk({tag, "_uf"},   {63'd0, o_uf_w}, 64'h0);
    chk({tag, "_rdy"},  {63'd0, bus.o_iq_rdy}, 64'h0);
  endtask

  initial begin
    int cnt, guard;
    tbl[0] = '{81,  0, 64'h5100_0000_0000_0000, ONES, 8'hFF};
    tbl[1] = '{81,  1, 64'h5100_0000_0000_0000, ONES, 8'hFF};
    tbl[2] = '{82,  0, 64'h0,                  64'h0, 8'hFF};
    tbl[3] = '{144, 0, 64'h9000_0000_0000_0000, ONES, 8'hFF};
    tbl[4] = '{145, 1, 64'h9100_0000_0000_0000, ONES, 8'hFF};
    tbl[5] = '{208, 0, 64'hD000_0000_0000_0000, ONES, 8'hFF};
    tbl[6] = '{209, 1, 64'hD100_0000_0000_0000, ONES, 8'hFF};
    tbl[7] = '{209, 2, 64'h0,                   ONES, 8'h00};
    tbl[8] = '{209, 4, SYNC,                    ONES, 8'h00};
    tbl[9] = '{209, 30, 64'h0,                  ONES, 8'h00};

    rst_n = 1'b0; hfp = 1'b0; test_mode = 1'b0;
    bus.i_iq_vld = 1'b0; bus.i_iq_data = 64'h0;
    m_slot = 0; m_uf = 1'b0; m_cnt = 16'd0;
    lseq = 0; lx = 0; ltake = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    #1 rst_n = 1'b1;

    // restart pulse, then two frames with continuous valid and incrementing words
    w = 64'd1;
    step(1'b1, w, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 1; i < 2 * FRAME; i++) begin
      step(1'b1, w, 1'b0, 1'b0);
      if (ltake) begin
        w = w + 64'd1;
        if (i >= FRAME) cnt++;
      end
    end
    chk("pl_per_frame", 64'(cnt), 64'd69);
    chk("words_in_order", w, 64'd139);

    // missing word in slot 10
    guard = 0;
    while (m_slot % FRAME != 10 && guard < 200) begin
      step(1'b1, w, 1'b0, 1'b0);
      if (ltake) w = w + 64'd1;
      guard++;
    end
    chk("uf_before", {63'd0, o_uf_w}, 64'h0);
    step(1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0);
    chk("uf_slot_seq",  {57'd0, bus.o_cpri_tx_seq}, 64'd10);
    chk("uf_slot_data", bus.o_cpri_tx_data, 64'h0);
    chk("uf_set",       {63'd0, o_uf_w}, 64'h1);
    step(1'b1, w, 1'b0, 1'b0);
    chk("uf_next_word", bus.o_cpri_tx_data, w);
    w = w + 64'd1;

    // random traffic up to frame 7, slot 50, then a mid-frame restart
    guard = 0;
    while (m_slot != 7 * FRAME + 50 && guard < 2000) begin
      step(($urandom_range(3) != 0), rnd64(), 1'b0, 1'b0);
      guard++;
    end
    chk("reach_x7_s50", 64'(m_slot), 64'(7 * FRAME + 50));
    step(1'b1, rnd64(), 1'b1, 1'b0);
    chk("hfp_mid_seq", {57'd0, bus.o_cpri_tx_seq}, 64'd0);
    chk("hfp_mid_ohfp", {63'd0, o_hfp_w}, 64'h1);
    chk("uf_sticky", {63'd0, o_uf_w}, 64'h1);

    // control-word table and slot map vectors
    for (int k = 0; k < 10; k++) begin
      guard = 0;
      while (m_slot != tbl[k].x * FRAME + tbl[k].seq && guard < HYPER) begin
        step(($urandom_range(3) != 0), rnd64(), 1'b0, 1'b0);
        guard++;
      end
      step(1'b1, rnd64(), 1'b0, 1'b0);
      chk($sformatf("vec%0d_seq", k),  {57'd0, bus.o_cpri_tx_seq}, 64'(tbl[k].seq));
      chk($sformatf("vec%0d_data", k), bus.o_cpri_tx_data, tbl[k].data);
      chk($sformatf("vec%0d_mask", k), bus.o_cpri_tx_mask, tbl[k].mask);
      chk($sformatf("vec%0d_crtl", k), {56'd0, bus.o_cpri_tx_crtl}, {56'd0, tbl[k].crtl});
    end

    // async reset while slot 30 is on the output
    guard = 0;
    while (lseq != 30 && guard < 200) begin
      step(1'b1, rnd64(), 1'b0, 1'b0);
      guard++;
    end
    chk("reach_s30", 64'(lseq), 64'd30);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    m_slot = 0; m_uf = 1'b0; m_cnt = 16'd0;
    step(1'b1, rnd64(), 1'b0, 1'b0);
    chk("rst_restart_seq", {57'd0, bus.o_cpri_tx_seq}, 64'd0);
    chk("rst_restart_hfp", {63'd0, o_hfp_w}, 64'h1);
    for (int i = 0; i < 60; i++) step(1'b1, rnd64(), 1'b0, 1'b0);

`ifdef IQ_TX_TEST_PATTERN_EN
    // test pattern: counter words, no ready, no underflow
    step(1'b0, 64'h0, 1'b1, 1'b1);
    for (int i = 0; i < FRAME + 10; i++) begin
      step(($urandom_range(1) != 0), rnd64(), 1'b0, 1'b1);
      if (lseq == 7)
        chk("tp_second_word", bus.o_cpri_tx_data, {4{16'h0001}});
    end
    chk("tp_no_uf", {63'd0, o_uf_w}, 64'h0);
    step(1'b1, rnd64(), 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
